// File: rtl/lowfreq_tone_pkg.sv
// Shared definitions for the four-channel low-frequency tone generator:
// default sizes, channel-index width and the per-channel state encoding.
package lowfreq_tone_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int ACC_W_DEF  = 32;
  localparam int CNT_W_DEF  = 32;
  localparam int CH_W       = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_TAIL = 2'd2,
    ST_DONE = 2'd3
  } ch_state_t;

endpackage

// File: rtl/lowfreq_tone_gen_nco_ch.sv
// One tone channel: phase accumulator, rising-edge counter and burst FSM.
// LOWFREQ_TONE_PHASE_OFFSET_EN adds a per-channel start phase.
module tone_nco_ch
  import lowfreq_tone_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [ACC_W-1:0] cfg_inc,
  input  logic [CNT_W-1:0] cfg_burst,
`ifdef LOWFREQ_TONE_PHASE_OFFSET_EN
  input  logic [ACC_W-1:0] cfg_phase,
`endif
  input  logic             start,
  input  logic             stop,
  output logic             out_signal,
  output logic             busy,
  output logic             done
);

  ch_state_t        state_reg;
  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] inc_reg;
  logic [CNT_W-1:0] burst_reg;
  logic [CNT_W-1:0] edge_cnt_reg;
  logic             out_reg;
  logic             done_reg;

  logic [ACC_W-1:0] acc_next;
  logic [ACC_W-1:0] start_acc;
  logic [CNT_W-1:0] edge_cnt_next;
  logic             out_next;
  logic             rise;

`ifdef LOWFREQ_TONE_PHASE_OFFSET_EN
  logic [ACC_W-1:0] phase_reg;
  assign start_acc = phase_reg;
`else
  assign start_acc = '0;
`endif

  assign acc_next      = acc_reg + inc_reg;
  assign out_next      = acc_next[ACC_W-1];
  assign rise          = out_next & ~out_reg;
  assign edge_cnt_next = edge_cnt_reg + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      acc_reg      <= '0;
      inc_reg      <= '0;
      burst_reg    <= '0;
      edge_cnt_reg <= '0;
      out_reg      <= 1'b0;
      done_reg     <= 1'b0;
`ifdef LOWFREQ_TONE_PHASE_OFFSET_EN
      phase_reg    <= '0;
`endif
    end else begin
      // Config lands in the same edge as a start; the start still sees the old values.
      if (cfg_we) begin
        inc_reg   <= cfg_inc;
        burst_reg <= cfg_burst;
`ifdef LOWFREQ_TONE_PHASE_OFFSET_EN
        phase_reg <= cfg_phase;
`endif
      end
      if (stop) begin
        state_reg <= ST_IDLE;
        acc_reg   <= '0;
        out_reg   <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE, ST_DONE: begin
            if (start && (inc_reg != '0)) begin
              state_reg    <= ST_RUN;
              acc_reg      <= start_acc;
              edge_cnt_reg <= '0;
              out_reg      <= start_acc[ACC_W-1];
              done_reg     <= 1'b0;
            end
          end
          ST_RUN: begin
            acc_reg <= acc_next;
            out_reg <= out_next;
            if (rise) begin
              edge_cnt_reg <= edge_cnt_next;
              if ((burst_reg != '0) && (edge_cnt_next == burst_reg))
                state_reg <= ST_TAIL;
            end
          end
          ST_TAIL: begin
            // Finish the last high phase so the final period is whole.
            acc_reg <= acc_next;
            out_reg <= out_next;
            if (out_reg && !out_next) begin
              done_reg  <= 1'b1;
              state_reg <= ST_DONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign out_signal = out_reg;
  assign done       = done_reg;
  assign busy       = (state_reg == ST_RUN) || (state_reg == ST_TAIL);

endmodule

// File: rtl/lowfreq_tone_gen.sv
// Four-channel NCO square-wave source for counter self-test; holds the config
// demux and ready mux. LOWFREQ_TONE_PHASE_OFFSET_EN adds the cfg_phase port.
module lowfreq_tone_gen
  import lowfreq_tone_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [CNT_W-1:0]  cfg_burst,
`ifdef LOWFREQ_TONE_PHASE_OFFSET_EN
  input  logic [ACC_W-1:0]  cfg_phase,
`endif
  input  logic [NUM_CH-1:0] start_mask,
  input  logic [NUM_CH-1:0] stop_mask,
  output logic [NUM_CH-1:0] out_signal,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] done
);

  logic [NUM_CH-1:0] cfg_we;

  // Unmapped channel indices stay ready so the write is simply discarded.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i))
        cfg_ready = !busy[i];
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign cfg_we[gi] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(gi));

      tone_nco_ch #(
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
      ) u_ch (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we[gi]),
        .cfg_inc    (cfg_inc),
        .cfg_burst  (cfg_burst),
`ifdef LOWFREQ_TONE_PHASE_OFFSET_EN
        .cfg_phase  (cfg_phase),
`endif
        .start      (start_mask[gi]),
        .stop       (stop_mask[gi]),
        .out_signal (out_signal[gi]),
        .busy       (busy[gi]),
        .done       (done[gi])
      );
    end
  endgenerate

endmodule
